// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_ctrl
// Description : Multicycle MIPS control FSM. Sequences fetch, decode, execute,
//               memory and write-back for R-type, LW/LB/SW/SB, BEQ/BNE, J,
//               ADDI/ANDI/ORI/SLTI and HALT. Adds a memory-ready handshake,
//               a retired-instruction counter and illegal-opcode reporting.
// Ports       : clk, reset (async, active-low), op (IR opcode field),
//               mem_ready (memory access completes this cycle);
//               datapath/memory control strobes (MemRead ... ALUOP),
//               halted, illegal_op (one-cycle pulse), instr_count.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl #(
    parameter int          ALUOP_W       = 6,
    parameter int          CNT_W         = 32,
    parameter int          USE_MEM_READY = 1,
    parameter logic [5:0]  HALT_OP       = 6'b111111
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic               mem_ready,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemByte,
    output logic               PCWriteCond,
    output logic               BranchNE,
    output logic               PCWrite,
    output logic [1:0]         PCSource,
    output logic               IorD,
    output logic               MemToReg,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               RegDst,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               ExtOp,
    output logic [ALUOP_W-1:0] ALUOP,
    output logic               halted,
    output logic               illegal_op,
    output logic [CNT_W-1:0]   instr_count
);

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_bne   = 6'b000101;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_slti  = 6'b001010;
    localparam logic [5:0] c_op_andi  = 6'b001100;
    localparam logic [5:0] c_op_ori   = 6'b001101;
    localparam logic [5:0] c_op_lb    = 6'b100000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sb    = 6'b101000;
    localparam logic [5:0] c_op_sw    = 6'b101011;

    localparam logic [ALUOP_W-1:0] c_alu_add   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] c_alu_sub   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] c_alu_funct = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] c_alu_and   = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] c_alu_or    = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] c_alu_slt   = ALUOP_W'(5);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_RTYPE_EX  = 4'd6,
        S_RTYPE_WB  = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ITYPE_EX  = 4'd10,
        S_ITYPE_WB  = 4'd11,
        S_HALT      = 4'd12
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_illegal;
    logic             w_ready;
    logic             w_retire;

    // With the handshake disabled every memory access completes in one cycle.
    assign w_ready = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

    // The cycle that leaves a final state of an instruction retires it.
    assign w_retire = (r_state == S_MEM_WB)   || (r_state == S_RTYPE_WB) ||
                      (r_state == S_ITYPE_WB) || (r_state == S_BRANCH)   ||
                      (r_state == S_JUMP)     ||
                      ((r_state == S_MEM_WRITE) && w_ready);

    assign instr_count = r_count;
    assign illegal_op  = r_illegal;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_count   <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= 1'b0;
            if (w_retire) begin
                r_count <= r_count + CNT_W'(1);
            end
            case (r_state)
                S_FETCH:     if (w_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    // HALT_OP is checked first so it wins over any overlap.
                    if (op == HALT_OP) begin
                        r_state <= S_HALT;
                    end else begin
                        case (op)
                            c_op_lw, c_op_lb, c_op_sw, c_op_sb:
                                r_state <= S_MEM_ADDR;
                            c_op_rtype:
                                r_state <= S_RTYPE_EX;
                            c_op_beq, c_op_bne:
                                r_state <= S_BRANCH;
                            c_op_j:
                                r_state <= S_JUMP;
                            c_op_addi, c_op_andi, c_op_ori, c_op_slti:
                                r_state <= S_ITYPE_EX;
                            default: begin
                                // Registered, so the pulse shows in the next FETCH cycle.
                                r_illegal <= 1'b1;
                                r_state   <= S_FETCH;
                            end
                        endcase
                    end
                end
                S_MEM_ADDR:  r_state <= ((op == c_op_lw) || (op == c_op_lb)) ?
                                        S_MEM_READ : S_MEM_WRITE;
                S_MEM_READ:  if (w_ready) r_state <= S_MEM_WB;
                S_MEM_WB:    r_state <= S_FETCH;
                S_MEM_WRITE: if (w_ready) r_state <= S_FETCH;
                S_RTYPE_EX:  r_state <= S_RTYPE_WB;
                S_RTYPE_WB:  r_state <= S_FETCH;
                S_BRANCH:    r_state <= S_FETCH;
                S_JUMP:      r_state <= S_FETCH;
                S_ITYPE_EX:  r_state <= S_ITYPE_WB;
                S_ITYPE_WB:  r_state <= S_FETCH;
                S_HALT:      r_state <= S_HALT;
                default:     r_state <= S_FETCH;
            endcase
        end
    end

    // Moore decode of the state; only the FETCH IR/PC load looks at mem_ready.
    // While reset is low every output stays at its default of zero.
    always_comb begin
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemByte     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNE    = 1'b0;
        PCWrite     = 1'b0;
        PCSource    = 2'b00;
        IorD        = 1'b0;
        MemToReg    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ExtOp       = 1'b0;
        ALUOP       = c_alu_add;
        halted      = 1'b0;
        if (reset) begin
            case (r_state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = w_ready;
                    PCWrite = w_ready;
                end
                S_DECODE:   ALUSrcB = 2'b11;
                S_MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEM_READ: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                    MemByte = (op == c_op_lb);
                end
                S_MEM_WB: begin
                    RegWrite = 1'b1;
                    MemToReg = 1'b1;
                end
                S_MEM_WRITE: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                    MemByte  = (op == c_op_sb);
                end
                S_RTYPE_EX: begin
                    ALUSrcA = 1'b1;
                    ALUOP   = c_alu_funct;
                end
                S_RTYPE_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOP       = c_alu_sub;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    BranchNE    = (op == c_op_bne);
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                S_ITYPE_EX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ExtOp   = (op == c_op_andi) || (op == c_op_ori);
                    case (op)
                        c_op_andi: ALUOP = c_alu_and;
                        c_op_ori:  ALUOP = c_alu_or;
                        c_op_slti: ALUOP = c_alu_slt;
                        default:   ALUOP = c_alu_add;
                    endcase
                end
                S_ITYPE_WB: RegWrite = 1'b1;
                S_HALT:     halted   = 1'b1;
                default:    halted   = 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Parametrised multicycle MIPS control FSM, successor to the single-state controller; sits between instruction register opcode field and datapath/memory.
- Implements the full fetch/decode/execute/memory/writeback sequence for R-type, load/store (word and byte), branch (BEQ/BNE), jump, immediate ALU ops and HALT.
- Adds a memory-ready handshake, retired-instruction counter and illegal-opcode reporting.

Parameters:
- ALUOP_W, 6, width of ALUOP output (minimum 3).
- CNT_W, 32, width of retired-instruction counter.
- USE_MEM_READY, 1, 1 = memory states wait for mem_ready; 0 = mem_ready treated as constant 1.
- HALT_OP, 6'b111111, opcode that enters HALT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  6  opcode from instruction register.
- mem_ready  in  1  memory access complete this cycle.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- MemByte  out  1  byte access (LB/SB).
- PCWriteCond  out  1  conditional PC write (branch).
- BranchNE  out  1  1 = branch on not-equal.
- PCWrite  out  1  unconditional PC write.
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- IorD  out  1  0 = PC addresses memory, 1 = ALUOut.
- MemToReg  out  1  1 = write-back from memory data register.
- IRWrite  out  1  load instruction register.
- RegWrite  out  1  register file write.
- RegDst  out  1  1 = rd, 0 = rt.
- ALUSrcA  out  1  0 = PC, 1 = register A.
- ALUSrcB  out  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2.
- ExtOp  out  1  0 = sign-extend, 1 = zero-extend immediate.
- ALUOP  out  ALUOP_W  0 ADD, 1 SUB, 2 FUNCT, 3 AND, 4 OR, 5 SLT; upper bits 0.
- halted  out  1  FSM in HALT.
- illegal_op  out  1  one-cycle pulse on unknown opcode.
- instr_count  out  CNT_W  retired instructions.

Behaviour:
- Reset low (async): state=FETCH, instr_count=0, illegal_op=0; all control outputs forced 0 while reset low, halted=0.
- Outputs Moore-decoded from state; defaults all 0 / ALUOP=ADD.
- FETCH: MemRead=1, ALUSrcB=01. IRWrite=PCWrite=1 only in a cycle with mem_ready=1, then →DECODE; otherwise stay.
- DECODE: ALUSrcB=11 (branch target into ALUOut). Dispatch on op:
  - LW 100011 / LB 100000 / SW 101011 / SB 101000 → MEM_ADDR.
  - R-type 000000 → RTYPE_EX.
  - BEQ 000100 / BNE 000101 → BRANCH.
  - J 000010 → JUMP.
  - ADDI 001000 / ANDI 001100 / ORI 001101 / SLTI 001010 → ITYPE_EX.
  - HALT_OP → HALT.
  - Otherwise illegal_op=1 for one cycle, →FETCH, not counted.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10; →MEM_READ (loads) or MEM_WRITE (stores).
- MEM_READ: MemRead=1, IorD=1, MemByte per op; wait for mem_ready, →MEM_WB.
- MEM_WB: RegWrite=1, MemToReg=1, RegDst=0; retire, →FETCH.
- MEM_WRITE: MemWrite=1, IorD=1, MemByte per op; held until mem_ready; retire on mem_ready, →FETCH.
- RTYPE_EX: ALUSrcA=1, ALUSrcB=00, ALUOP=FUNCT; →RTYPE_WB.
- RTYPE_WB: RegWrite=1, RegDst=1; retire, →FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOP=SUB, PCWriteCond=1, PCSource=01, BranchNE=(op==BNE); retire, →FETCH.
- JUMP: PCWrite=1, PCSource=10; retire, →FETCH.
- ITYPE_EX: ALUSrcA=1, ALUSrcB=10, ALUOP ADDI→ADD, ANDI→AND, ORI→OR, SLTI→SLT; ExtOp=1 for ANDI/ORI; →ITYPE_WB.
- ITYPE_WB: RegWrite=1, RegDst=0; retire, →FETCH.
- HALT: halted=1, all strobes 0; exit only via reset.
- Op decode in states after DECODE uses current op (IR stable since IRWrite=0).
- Latency with mem_ready constantly 1: J/BEQ/BNE 3 cycles, R-type/I-type/store 4, load 5; each mem_ready=0 cycle adds one.
- instr_count increments by 1 on the retiring transition, wraps modulo 2^CNT_W.
- Reset asserted mid-instruction: immediate return to FETCH, count cleared; no partial writes after reset edge.

Test Plan:
- Reset, op=000000, mem_ready=1 → states FETCH,DECODE,RTYPE_EX,RTYPE_WB; RegWrite=1,RegDst=1 in cycle 4; instr_count=1.
- LW 100011 with mem_ready low 2 cycles in MEM_READ → 7-cycle instruction; MemRead held, IorD=1; MemToReg=1,RegWrite=1 in final cycle.
- BNE 000101 → BRANCH has PCWriteCond=1, BranchNE=1, PCSource=01, ALUOP=1; 3 cycles.
- ORI 001101 → ITYPE_EX has ALUOP=4, ExtOp=1, ALUSrcB=10; op=010000 → illegal_op pulse, back to FETCH, count unchanged.
- op=111111 → halted=1 permanently; assert reset low mid-MEM_WRITE → outputs 0 at once, FETCH after release, instr_count=0.
- CNT_W=4, 16 J instructions → instr_count wraps to 0.
